// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response bundle between an initiator and the
//               mem_responder memory model.
//   req   - request strobe from the initiator
//   we    - 1 = store, 0 = load
//   addr  - byte address
//   wdata - store data
//   ready - one-cycle response pulse
//   rdata - load data, valid while ready=1
//   err   - request rejected, valid while ready=1
//   pass  - sticky completion flag
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        pass;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, err, pass
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, err, pass
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding-request memory responder. Accepts a
//               load/store in IDLE, waits WAIT cycles, then issues a
//               one-cycle registered response. Stores commit on the edge
//               that ends the response cycle. A store of PASS_DATA to
//               PASS_ADDR sets a sticky pass flag.
//   clk   - clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - request/response bundle (slave side)
// Parameters  : DEPTH (words, power of two 4..1024), WAIT (0..15),
//               PASS_ADDR, PASS_DATA
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WAIT      = 2,
  parameter logic [31:0] PASS_ADDR = 32'd84,
  parameter logic [31:0] PASS_DATA = 32'h07001111
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_responder_if.slave    bus
);

  localparam int unsigned c_idx_w = $clog2(DEPTH);
  localparam logic [31:0] c_limit = 32'(DEPTH * 4);
  localparam logic [3:0]  c_wait  = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAITING = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_we;
  logic [31:0]  r_addr;
  logic [31:0]  r_wdata;
  logic         r_ready;
  logic         r_err;
  logic [31:0]  r_rdata;
  logic         r_pass;

  logic [31:0]  r_mem [DEPTH];

  // Request fields used to build the response. The response is registered
  // on the edge entering RESP; with WAIT=0 that is the accepting edge, so the
  // live inputs are used while still in IDLE, otherwise the latched copy.
  logic               w_sel_we;
  logic [31:0]        w_sel_addr;
  logic               w_valid;
  logic [c_idx_w-1:0] w_idx;
  logic [31:0]        w_rd_word;
  logic               w_commit;
  logic [c_idx_w-1:0] w_commit_idx;

  always_comb begin
    w_sel_we   = r_we;
    w_sel_addr = r_addr;
    if (r_state == S_IDLE) begin
      w_sel_we   = bus.we;
      w_sel_addr = bus.addr;
    end
  end

  assign w_valid   = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr < c_limit);
  assign w_idx     = w_sel_addr[c_idx_w+1:2];
  assign w_rd_word = r_mem[w_idx];

  // In RESP, r_err already holds the validity verdict of the latched address,
  // so a rejected store never reaches the array or the pass detector. Reset
  // forces r_state to IDLE asynchronously, which also blocks the commit.
  assign w_commit     = (r_state == S_RESP) && r_we && !r_err;
  assign w_commit_idx = r_addr[c_idx_w+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            if (WAIT == 0) begin
              r_state <= S_RESP;
              r_cnt   <= 4'd0;
              r_ready <= 1'b1;
              r_err   <= !w_valid;
              r_rdata <= (w_valid && !w_sel_we) ? w_rd_word : 32'd0;
            end else begin
              r_state <= S_WAITING;
              r_cnt   <= c_wait;
            end
          end
        end

        S_WAITING: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_err   <= !w_valid;
            r_rdata <= (w_valid && !w_sel_we) ? w_rd_word : 32'd0;
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
          if (w_commit && (r_addr == PASS_ADDR) && (r_wdata == PASS_DATA)) begin
            r_pass <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Store contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_commit_idx] <= r_wdata;
    end
  end

  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;
  assign bus.pass  = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Two instances are
//               exercised: WAIT=2 (bus2) and WAIT=0 (bus0), both DEPTH=64.
//               Expected results come from a word-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam logic [31:0] PASS_DATA = 32'h07001111;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH(64), .WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  mem_responder #(.DEPTH(64), .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  always #5 clk = ~clk;

  // Reference model: word-indexed memory and pass flag per instance.
  logic [31:0] m2 [int];
  logic [31:0] m0 [int];
  bit          p2 = 1'b0;
  bit          p0 = 1'b0;

  function automatic bit addr_ok(logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'd256);
  endfunction

  function automatic logic get_ready(bit sel);
    return sel ? bus0.ready : bus2.ready;
  endfunction
  function automatic logic get_err(bit sel);
    return sel ? bus0.err : bus2.err;
  endfunction
  function automatic logic [31:0] get_rdata(bit sel);
    return sel ? bus0.rdata : bus2.rdata;
  endfunction
  function automatic logic get_pass(bit sel);
    return sel ? bus0.pass : bus2.pass;
  endfunction

  task automatic drive(bit sel, bit r, bit w, logic [31:0] a, logic [31:0] d);
    if (sel) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus2.req = r; bus2.we = w; bus2.addr = a; bus2.wdata = d;
    end
  endtask

  task automatic model_apply(bit sel, bit w, logic [31:0] a, logic [31:0] d,
                             output logic [31:0] exp_rd, output bit exp_err, output bit known);
    int key;
    key     = int'(a >> 2);
    exp_err = !addr_ok(a);
    exp_rd  = 32'd0;
    known   = 1'b1;
    if (!exp_err) begin
      if (w) begin
        if (sel) m0[key] = d; else m2[key] = d;
        if (a == 32'd84 && d == PASS_DATA) begin
          if (sel) p0 = 1'b1; else p2 = 1'b1;
        end
      end else if (sel) begin
        if (m0.exists(key)) exp_rd = m0[key]; else known = 1'b0;
      end else begin
        if (m2.exists(key)) exp_rd = m2[key]; else known = 1'b0;
      end
    end
  endtask

  // One complete transaction; entered and left at #1 after an edge, DUT idle.
  task automatic xact(bit sel, bit w, logic [31:0] a, logic [31:0] d, string tag);
    int          lat;
    int          exp_lat;
    logic [31:0] rd;
    logic        e;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          known;
    exp_lat = sel ? 1 : 3;
    drive(sel, 1'b1, w, a, d);
    @(posedge clk); #1;
    // Scramble the idle request fields to show the latched copy is used.
    drive(sel, 1'b0, 1'($urandom), $urandom, $urandom);
    lat = 1;
    while (lat <= 20 && get_ready(sel) !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = get_rdata(sel);
    e  = get_err(sel);
    model_apply(sel, w, a, d, exp_rd, exp_err, known);
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++; $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, exp_lat);
    end
    n_cmp++;
    if (e !== exp_err) begin
      n_bad++; $display("FAIL %s err: got %b expected %b (addr %h)", tag, e, exp_err, a);
    end
    if (known) begin
      n_cmp++;
      if (rd !== exp_rd) begin
        n_bad++; $display("FAIL %s rdata: got %h expected %h (addr %h)", tag, rd, exp_rd, a);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (get_ready(sel) !== 1'b0) begin
      n_bad++; $display("FAIL %s ready width: got %b after response, expected 0", tag, get_ready(sel));
    end
    n_cmp++;
    if (get_pass(sel) !== (sel ? p0 : p2)) begin
      n_bad++; $display("FAIL %s pass: got %b expected %b", tag, get_pass(sel), sel ? p0 : p2);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 63) * 4);
    else if (r == 7) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    else             return 32'($urandom_range(64, 2000)) << 2;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus2.ready !== 1'b0) begin n_bad++; $display("FAIL reset ready2: got %b expected 0", bus2.ready); end
    n_cmp++; if (bus2.err !== 1'b0) begin n_bad++; $display("FAIL reset err2: got %b expected 0", bus2.err); end
    n_cmp++; if (bus2.rdata !== 32'd0) begin n_bad++; $display("FAIL reset rdata2: got %h expected 0", bus2.rdata); end
    n_cmp++; if (bus2.pass !== 1'b0) begin n_bad++; $display("FAIL reset pass2: got %b expected 0", bus2.pass); end
    n_cmp++; if (bus0.ready !== 1'b0) begin n_bad++; $display("FAIL reset ready0: got %b expected 0", bus0.ready); end
    n_cmp++; if (bus0.pass !== 1'b0) begin n_bad++; $display("FAIL reset pass0: got %b expected 0", bus0.pass); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "st_10");
    xact(1'b0, 1'b0, 32'h10, 32'h0, "ld_10");
  endtask

  task automatic test_invalid();
    xact(1'b0, 1'b0, 32'h102, 32'h0, "ld_misal");
    xact(1'b0, 1'b0, 32'd256, 32'h0, "ld_range");
    xact(1'b0, 1'b1, 32'h110, 32'h12345678, "st_alias");
    xact(1'b0, 1'b1, 32'h112, 32'h87654321, "st_misal");
    xact(1'b0, 1'b1, 32'd340, PASS_DATA, "st_pass_alias");
    xact(1'b0, 1'b1, 32'd86, PASS_DATA, "st_pass_misal");
    xact(1'b0, 1'b0, 32'h10, 32'h0, "ld_10_kept");
  endtask

  task automatic test_pass();
    xact(1'b0, 1'b1, 32'd84, PASS_DATA, "pass_set");
    xact(1'b0, 1'b1, 32'd84, 32'd0, "pass_overwrite");
    xact(1'b0, 1'b1, 32'd80, PASS_DATA, "pass_other");
    xact(1'b0, 1'b0, 32'd84, 32'd0, "pass_ld84");
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    int          pulses;
    int          k;
    for (int i = 0; i < 4; i++) begin
      addrs[i] = 32'($urandom_range(0, 63) * 4);
      xact(1'b0, 1'b1, addrs[i], $urandom, "b2b_fill");
    end
    pulses = 0;
    drive(1'b0, 1'b1, 1'b0, addrs[0], 32'd0);
    for (int c = 0; c <= 20; c++) begin
      if (c > 0 && bus2.ready === 1'b1) begin
        n_cmp++;
        if (pulses > 3 || c != 3 + 4 * pulses) begin
          n_bad++; $display("FAIL b2b timing: ready in cycle %0d, expected cycle %0d", c, 3 + 4 * pulses);
        end else begin
          n_cmp++;
          if (bus2.rdata !== m2[int'(addrs[pulses] >> 2)]) begin
            n_bad++; $display("FAIL b2b rdata: got %h expected %h", bus2.rdata, m2[int'(addrs[pulses] >> 2)]);
          end
        end
        pulses++;
      end
      if (c % 4 == 1) begin
        k = c / 4 + 1;
        if (k < 4) bus2.addr = addrs[k];
        else       bus2.req  = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (pulses !== 4) begin
      n_bad++; $display("FAIL b2b count: got %0d responses, expected 4", pulses);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] keep20;
    logic [31:0] keep24;
    keep20 = $urandom;
    keep24 = $urandom;
    xact(1'b0, 1'b1, 32'h20, keep20, "abort_fill20");
    xact(1'b0, 1'b1, 32'h24, keep24, "abort_fill24");
    // Abort in WAITING.
    drive(1'b0, 1'b1, 1'b1, 32'h20, ~keep20);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus2.ready !== 1'b0) begin n_bad++; $display("FAIL abort_wait ready: got %b expected 0", bus2.ready); end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    p2 = 1'b0;
    p0 = 1'b0;
    n_cmp++;
    if (bus2.pass !== 1'b0) begin n_bad++; $display("FAIL abort pass cleared: got %b expected 0", bus2.pass); end
    @(posedge clk); #1;
    xact(1'b0, 1'b0, 32'h20, 32'h0, "abort_ld20");
    // Abort in RESP: the response pulse must vanish and the store not commit.
    drive(1'b0, 1'b1, 1'b1, 32'h24, ~keep24);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus2.ready !== 1'b1) begin n_bad++; $display("FAIL abort_resp pre: ready got %b expected 1", bus2.ready); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus2.ready !== 1'b0) begin n_bad++; $display("FAIL abort_resp ready: got %b expected 0", bus2.ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 1'b0, 32'h24, 32'h0, "abort_ld24");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      xact(1'b0, 1'($urandom), rand_addr(), $urandom, "rand2");
    end
  endtask

  task automatic test_wait0();
    xact(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, "w0_st");
    xact(1'b1, 1'b0, 32'h10, 32'h0, "w0_ld");
    xact(1'b1, 1'b0, 32'h102, 32'h0, "w0_misal");
    xact(1'b1, 1'b1, 32'd84, PASS_DATA, "w0_pass");
    for (int i = 0; i < 15; i++) begin
      xact(1'b1, 1'($urandom), rand_addr(), $urandom, "rand0");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store_load();
    test_invalid();
    test_pass();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_wait0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
